fifo_joiner_parametrized: RTL and testbench
===========================================

// Module: fifo_joiner_parametrized
// PURPOSE
//   Many-to-one counterpart of fifo_splitter_parametrized. Accepts CHANNELS independent valid/ready
//   streams and emits one concatenated word only after every channel has delivered exactly one item.
//   Used to re-synchronise per-layer side streams, e.g. layer number + activations + targets, before
//   a consumer that needs all of them in the same cycle. Fully registered; sustains one join per cycle.
// PARAMETERS
//   DATA_WIDTH  2  width of each channel item (default matches LAYER_ADDR_WIDTH)
//   CHANNELS    2  number of input streams joined (>=2)
// PORTS
//   clk             in   1                      clock
//   rst             in   1                      reset: synchronous, active-high
//   data_in         in   CHANNELS*DATA_WIDTH    channel i item at [i*DATA_WIDTH +: DATA_WIDTH]
//   data_in_valid   in   CHANNELS               bit i: channel i item valid
//   data_in_ready   out  CHANNELS               bit i: channel i slot can accept
//   data_out        out  CHANNELS*DATA_WIDTH    joined word, same channel packing as data_in
//   data_out_valid  out  1                      joined word valid
//   data_out_ready  in   1                      downstream accepts joined word
//   join_count      out  32                     joins delivered (JOINER_STATS_EN only)
//   stall_cycles    out  32                     cycles with data_out_valid && !data_out_ready (JOINER_STATS_EN only)
// BEHAVIOUR
//   - Storage: per channel one slot (slot_data[i], slot_full[i]); one output register (data_out, data_out_valid).
//   - transfer = &slot_full && (!data_out_valid || data_out_ready); no dependence on data_in_valid.
//   - data_in_ready[i] = !slot_full[i] || transfer (combinational; no valid->ready path).
//   - Slot i loads on posedge when data_in_valid[i] && data_in_ready[i]; slot_full[i] <= 1.
//   - On transfer edge: data_out <= {slot_data}, data_out_valid <= 1, all slot_full cleared unless that
//     channel loads on same edge (load wins: slot_full stays 1 with new data).
//   - Output consumed (valid && ready) with no transfer: data_out_valid <= 0; data_out holds last value.
//   - Latency: item arriving last at edge E appears on data_out after edge E+1 (2 edges from acceptance).
//   - Throughput: all channels valid every cycle and data_out_ready=1 -> one join per cycle after fill.
//   - A channel that runs ahead holds exactly one item, then deasserts ready until the others catch up;
//     items are never reordered, duplicated or dropped; channel i's k-th item pairs with every other's k-th.
//   - Backpressure: data_out_valid && !data_out_ready -> data_out stable; slots may still fill (one each).
//   - Reset: slot_full=0, slot_data=0, data_out=0, data_out_valid=0, counters=0; data_in_ready = all ones
//     in the first cycle after reset. Reset mid-operation discards partial slots and any held output.
//   - data_in_valid may drop without handshake; data is sampled only on handshake edges.
// CONFIGURATION
//   JOINER_STATS_EN defined: join_count increments on every data_out handshake (valid && ready);
//     stall_cycles increments every cycle data_out_valid && !data_out_ready; both wrap at 2^32.
//   JOINER_STATS_EN undefined: join_count and stall_cycles ports absent; no counter logic.
// TESTING
//   1 reset: hold rst 3 cycles -> data_out_valid=0, data_out=0, data_in_ready=2'b11, counters 0.
//   2 basic join (W=2,C=2): ch0=2'd1 at cycle 1, ch1=2'd3 at cycle 4 -> data_out=4'b1101 valid
//     after cycle-5 edge; data_in_ready[0]=0 during cycles 2..4.
//   3 streaming: both channels valid every cycle with 0..7, data_out_ready=1 -> 8 joins on consecutive
//     cycles, word k = {k,k}, join_count=8, stall_cycles=0.
//   4 backpressure: data_out_ready=0 for 5 cycles with both inputs valid -> data_out stable, each slot
//     takes one item then ready=0; stall_cycles=5; on release, next word follows with no gap, no loss.
//   5 skew: ch0 sends 1,2,3 back-to-back, ch1 sends 0,0,0 spaced 4 cycles -> words {0,1},{0,2},{0,3}
//     in order; ch0 ready low while its slot is full and no transfer.
//   6 reset mid-op: ch0 slot full, output valid unaccepted, assert rst 1 cycle -> all state cleared,
//     next join uses only post-reset items.

Source files
------------

// File: rtl/fifo_joiner_parametrized.sv
// Joins CHANNELS valid/ready streams into one registered word, one item per channel.
// Define JOINER_STATS_EN to add the join_count / stall_cycles counters.
module fifo_joiner_parametrized #(
    parameter int DATA_WIDTH = 2,
    parameter int CHANNELS   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    input  logic [CHANNELS-1:0]            data_in_valid,
    output logic [CHANNELS-1:0]            data_in_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic                           data_out_valid,
    input  logic                           data_out_ready
`ifdef JOINER_STATS_EN
    ,
    output logic [31:0]                    join_count,
    output logic [31:0]                    stall_cycles
`endif
);

    localparam int DW = CHANNELS * DATA_WIDTH;

    logic [DW-1:0]       slot_data_q, slot_data_d;
    logic [CHANNELS-1:0] slot_full_q, slot_full_d;
    logic [DW-1:0]       out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                transfer;
    logic [CHANNELS-1:0] load;

    always_comb begin
        transfer      = (&slot_full_q) && (!out_valid_q || data_out_ready);
        data_in_ready = ~slot_full_q | {CHANNELS{transfer}};
        load          = data_in_valid & data_in_ready;

        // A load on the transfer edge keeps the slot full with the new item.
        slot_full_d = transfer ? '0 : slot_full_q;
        slot_full_d = slot_full_d | load;

        slot_data_d = slot_data_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (load[i]) begin
                slot_data_d[i*DATA_WIDTH +: DATA_WIDTH] =
                    data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (transfer) begin
            out_data_d  = slot_data_q;
            out_valid_d = 1'b1;
        end else if (out_valid_q && data_out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_data_q <= '0;
            slot_full_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            slot_data_q <= slot_data_d;
            slot_full_q <= slot_full_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign data_out       = out_data_q;
    assign data_out_valid = out_valid_q;

`ifdef JOINER_STATS_EN
    logic [31:0] join_count_q, join_count_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        join_count_d   = join_count_q;
        stall_cycles_d = stall_cycles_q;
        if (out_valid_q && data_out_ready) begin
            join_count_d = join_count_q + 32'd1;
        end
        if (out_valid_q && !data_out_ready) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            join_count_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            join_count_q   <= join_count_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign join_count   = join_count_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_fifo_joiner_parametrized.sv
// Directed bench for fifo_joiner_parametrized (DATA_WIDTH=2, CHANNELS=2).
// Stats checks are compiled in when JOINER_STATS_EN is defined.
module tb_fifo_joiner_parametrized;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] data_in = '0;
    logic [1:0] data_in_valid = '0;
    logic [1:0] data_in_ready;
    logic [3:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready = 1'b1;
`ifdef JOINER_STATS_EN
    logic [31:0] join_count;
    logic [31:0] stall_cycles;
`endif

    int vectors = 0;
    int miscompares = 0;

    fifo_joiner_parametrized #(
        .DATA_WIDTH(2),
        .CHANNELS  (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready)
`ifdef JOINER_STATS_EN
        ,
        .join_count    (join_count),
        .stall_cycles  (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        data_in_valid = '0;
        data_in = '0;
        data_out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        #1;
    endtask

    int ptr;
    logic [1:0] k2;
    logic [3:0] exp_word;
    bit [1:0] ch1_v;
    bit r0_tab [1:10] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 1};

    initial begin
        // reset state
        do_reset();
        chk("rst_valid", 32'(data_out_valid), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_ready", 32'(data_in_ready), 32'd3);
`ifdef JOINER_STATS_EN
        chk("rst_joins", join_count, 32'd0);
        chk("rst_stalls", stall_cycles, 32'd0);
`endif

        // basic join: ch0 early, ch1 three cycles later
        data_in = 4'b0001;
        data_in_valid = 2'b01;
        tick();
        data_in_valid = 2'b00;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("basic_ready0", 32'(data_in_ready), 32'b10);
            chk("basic_nov", 32'(data_out_valid), 32'd0);
            if (i < 2) tick();
        end
        data_in = 4'b1100;
        data_in_valid = 2'b10;
        tick();
        data_in_valid = 2'b00;
        chk("basic_pre", 32'(data_out_valid), 32'd0);
        tick();
        chk("basic_valid", 32'(data_out_valid), 32'd1);
        chk("basic_word", 32'(data_out), 32'b1101);
        tick();
        chk("basic_drain", 32'(data_out_valid), 32'd0);
        chk("basic_hold", 32'(data_out), 32'b1101);

        // streaming: one join per cycle
        do_reset();
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                k2 = 2'(i);
                data_in = {k2, k2};
                data_in_valid = 2'b11;
            end else begin
                data_in_valid = 2'b00;
            end
            tick();
            if (i == 0) begin
                chk("strm_v0", 32'(data_out_valid), 32'd0);
            end else begin
                k2 = 2'(i - 1);
                exp_word = {k2, k2};
                chk("strm_valid", 32'(data_out_valid), 32'd1);
                chk("strm_word", 32'(data_out), 32'(exp_word));
            end
            if (i > 0 && i < 8) chk("strm_ready", 32'(data_in_ready), 32'd3);
        end
        tick();
        chk("strm_end", 32'(data_out_valid), 32'd0);
`ifdef JOINER_STATS_EN
        chk("strm_joins", join_count, 32'd8);
        chk("strm_stalls", stall_cycles, 32'd0);
`endif

        // backpressure: 5 stalled cycles
        do_reset();
        data_out_ready = 1'b0;
        data_in = 4'h5;
        data_in_valid = 2'b11;
        tick();
        data_in = 4'hA;
        tick();
        chk("bp_first", 32'(data_out), 32'h5);
        data_in = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_stable", 32'(data_out), 32'h5);
            chk("bp_ready", 32'(data_in_ready), 32'd0);
        end
`ifdef JOINER_STATS_EN
        chk("bp_stalls", stall_cycles, 32'd5);
`endif
        data_out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(data_in_ready), 32'd3);
        tick();
        data_in_valid = 2'b00;
        chk("bp_next", 32'(data_out), 32'hA);
        chk("bp_next_v", 32'(data_out_valid), 32'd1);
        tick();
        chk("bp_last", 32'(data_out), 32'hF);
        chk("bp_last_v", 32'(data_out_valid), 32'd1);
        tick();
        chk("bp_done", 32'(data_out_valid), 32'd0);
`ifdef JOINER_STATS_EN
        chk("bp_joins", join_count, 32'd3);
        chk("bp_stalls2", stall_cycles, 32'd5);
`endif

        // skew: ch0 runs ahead, ch1 every 4 cycles
        do_reset();
        ptr = 0;
        for (int c = 1; c <= 10; c++) begin
            ch1_v = (c == 1 || c == 5 || c == 9) ? 2'b10 : 2'b00;
            k2 = 2'(ptr + 1);
            data_in = {2'b00, k2};
            data_in_valid = ch1_v | ((ptr < 3) ? 2'b01 : 2'b00);
            #1;
            chk("skew_ready0", 32'(data_in_ready[0]), 32'(r0_tab[c]));
            if (data_in_valid[0] && data_in_ready[0]) ptr++;
            tick();
            case (c)
                2:       exp_word = 4'b0001;
                6:       exp_word = 4'b0010;
                10:      exp_word = 4'b0011;
                default: exp_word = 4'b0000;
            endcase
            if (c == 2 || c == 6 || c == 10) begin
                chk("skew_valid", 32'(data_out_valid), 32'd1);
                chk("skew_word", 32'(data_out), 32'(exp_word));
            end else begin
                chk("skew_idle", 32'(data_out_valid), 32'd0);
            end
        end
        data_in_valid = 2'b00;

        // reset mid-operation
        do_reset();
        data_out_ready = 1'b0;
        data_in = 4'h5;
        data_in_valid = 2'b11;
        tick();
        data_in = 4'hA;
        tick();
        data_in_valid = 2'b00;
        chk("mid_pre_v", 32'(data_out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_valid", 32'(data_out_valid), 32'd0);
        chk("mid_data", 32'(data_out), 32'd0);
        chk("mid_ready", 32'(data_in_ready), 32'd3);
        data_out_ready = 1'b1;
        data_in = 4'b0111;
        data_in_valid = 2'b11;
        tick();
        data_in_valid = 2'b00;
        tick();
        chk("mid_join_v", 32'(data_out_valid), 32'd1);
        chk("mid_join", 32'(data_out), 32'b0111);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
